// File: rtl/qs_fifo_flex.sv
// Synchronous elastic buffer for the qs datapath: any depth, FWFT or registered
// read, occupancy count, programmable almost flags and sticky error flags.
module qs_fifo_flex #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              overflow_o,
    output logic              underflow_o,
    input  logic              err_clr_i
);

    localparam int PTR_W_RAW = $clog2(DEPTH);
    localparam int PTR_W     = (PTR_W_RAW < 1) ? 1 : PTR_W_RAW;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              full;
    logic              empty;
    logic              push_acc;
    logic              pop_acc;
    logic              push_err;
    logic              pop_err;
    logic [DATA_W-1:0] head_data;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A push into a full FIFO is still taken when a pop frees the head slot.
    always_comb begin
        push_acc = push_i & (~full | pop_i);
        pop_acc  = pop_i & ~empty;
        push_err = push_i & full & ~pop_i;
        pop_err  = pop_i & empty;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Set has priority over clear so an error in the clearing cycle is not lost.
    always_comb begin
        overflow_d  = (overflow_q & ~err_clr_i) | push_err;
        underflow_d = (underflow_q & ~err_clr_i) | pop_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data = mem[rd_ptr_q];

    generate
        if (FWFT != 0) begin : g_fwft
            // Masked while empty so the uninitialised storage never leaks out.
            assign pop_data_o = empty ? '0 : head_data;
        end else begin : g_registered
            logic [DATA_W-1:0] pop_data_q, pop_data_d;

            always_comb begin
                pop_data_d = pop_data_q;
                if (pop_acc) begin
                    pop_data_d = head_data;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pop_data_q <= '0;
                end else begin
                    pop_data_q <= pop_data_d;
                end
            end

            assign pop_data_o = pop_data_q;
        end
    endgenerate

    assign count_o        = count_q;
    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count_q >= AF_LVL);
    assign almost_empty_o = (count_q <= AE_LVL);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule
